// File: rtl/wb_arbiter_scoreboard.sv
// Writeback arbiter between the ALU and load unit, with a per-register busy
// scoreboard that stalls issue on pending writes.
module wb_arbiter_scoreboard #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            mem_valid,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic            mem_ready,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   input  logic [4:0]      iss_rs1,
   input  logic [4:0]      iss_rs2,
   output logic            iss_stall,
   output logic            rf_wEn,
   output logic [4:0]      rf_write_sel,
   output logic [XLEN-1:0] rf_write_data,
   output logic [NREG-1:0] busy_vec
);

   typedef enum logic {LastAlu, LastMem} last_e;

   last_e           last_q, last_d;
   logic            acc;
   logic [4:0]      acc_rd;
   logic [XLEN-1:0] acc_data;
   logic            issue;
   logic            wen_q, wen_d;
   logic [4:0]      sel_q, sel_d;
   logic [XLEN-1:0] data_q, data_d;
   logic [NREG-1:0] busy_q, busy_d;

   // Grants are forced low while reset is held so no requester sees a bogus accept.
   always_comb begin
      alu_ready = 1'b0;
      mem_ready = 1'b0;
      if (!reset) begin
         if (alu_valid && mem_valid) begin
            if (last_q == LastMem) alu_ready = 1'b1;
            else                   mem_ready = 1'b1;
         end else begin
            alu_ready = alu_valid;
            mem_ready = mem_valid;
         end
      end
   end

   assign acc      = alu_ready | mem_ready;
   assign acc_rd   = mem_ready ? mem_rd : alu_rd;
   assign acc_data = mem_ready ? mem_data : alu_data;

   assign iss_stall = iss_valid & (busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd]);
   assign issue     = iss_valid & ~iss_stall & (iss_rd != 5'd0);

   always_comb begin
      last_d = last_q;
      if (alu_ready) last_d = LastAlu;
      if (mem_ready) last_d = LastMem;

      // Writes to x0 are consumed silently and leave the rf_* payload untouched.
      wen_d  = acc && (acc_rd != 5'd0);
      sel_d  = sel_q;
      data_d = data_q;
      if (wen_d) begin
         sel_d  = acc_rd;
         data_d = acc_data;
      end

      // Set is applied after clear so a same-edge collision leaves the bit set.
      busy_d = busy_q;
      if (wen_d) busy_d[acc_rd] = 1'b0;
      if (issue) busy_d[iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_q <= LastAlu;
         wen_q  <= 1'b0;
         sel_q  <= '0;
         data_q <= '0;
         busy_q <= '0;
      end else begin
         last_q <= last_d;
         wen_q  <= wen_d;
         sel_q  <= sel_d;
         data_q <= data_d;
         busy_q <= busy_d;
      end
   end

   assign rf_wEn        = wen_q;
   assign rf_write_sel  = sel_q;
   assign rf_write_data = data_q;
   assign busy_vec      = busy_q;

endmodule
